// File: rtl/operand_entry_fsm.sv
// Operand entry: synchronised, debounced, edge-detected load/clear buttons drive an A/B/READY FSM.
// Optional debounce filter enabled by defining OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_clr,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       operands_valid,
  output logic [1:0] entry_state
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } state_e;

  // Bit 0 is the load button, bit 1 the clear button.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] deb;
  logic [1:0] deb_dly_q;
  logic [1:0] pulse;

  assign btn_raw = {btn_clr, btn_load};

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_dly_q <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       deb_q;
  logic [CNT_W-1:0] cnt_q [2];

  // The level flips on the clock that would take the count to DEBOUNCE_CYCLES.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign deb = deb_q;
`else
  assign deb = sync2_q;
`endif

  assign pulse = deb & ~deb_dly_q;

  state_e     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       valid_q;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else if (pulse[1]) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (pulse[0]) begin
            a_q     <= sw;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (pulse[0]) begin
            b_q     <= sw;
            valid_q <= 1'b1;
            state_q <= READY;
          end
        end
        READY: begin
          if (pulse[0]) begin
            a_q     <= sw;
            valid_q <= 1'b0;
            state_q <= WAIT_B;
          end
        end
        default: begin
          state_q <= WAIT_A;
          a_q     <= '0;
          b_q     <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign operands_valid = valid_q;
  assign entry_state    = state_q;

endmodule

// File: doc/operand_entry_fsm.md
# operand_entry_fsm

Operand entry stage directly upstream of the 4-bit ripple adder. It turns four slide switches and two push buttons into registered operands `a` and `b`, which feed the adder and the A/B hex digits. The board buttons are synchronised, debounced and edge-detected. A small state machine loads A, then B, then flags the operand pair as complete.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable clocks (10 ms at 50 MHz) before a button level is accepted; minimum 1.
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W > `DEBOUNCE_CYCLES`.

Ports:
- `clk_50MHz` in 1: system clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Assertion is immediate; release is sampled on `clk_50MHz`.
- `sw` in 4: raw slide-switch value. Operands are quasi-static, so it is sampled directly with no synchroniser.
- `btn_load` in 1: raw, asynchronous load push button, active-high.
- `btn_clr` in 1: raw, asynchronous clear push button, active-high.
- `a` out 4: registered operand A.
- `b` out 4: registered operand B.
- `operands_valid` out 1: high while both A and B hold user-entered values.
- `entry_state` out 2: current FSM state, for LEDs.

## Operation
- Each button has its own path: two flip-flop synchroniser, then debounce filter, then rising-edge detector.
- Debounce filter:
  - It holds a debounced level `deb` and a counter.
  - While the synchronised level equals `deb`, the counter is cleared.
  - While the levels differ, the counter increments each clock. When it reaches `DEBOUNCE_CYCLES`, `deb` takes the new level and the counter clears.
  - Any bounce back to `deb` before the count completes clears the counter.
- Edge pulse:
  - `pulse = deb & ~deb_q`, where `deb_q` is `deb` delayed one clock.
  - It is high for exactly one clock per accepted press.
  - Releases produce no pulse.
- FSM states, `entry_state` encoding:
  - `WAIT_A`=2'b00
  - `WAIT_B`=2'b01
  - `READY`=2'b10
  - 2'b11 is illegal and returns to `WAIT_A`, also clearing `a`, `b` and `operands_valid`.
- Transitions on `load_pulse`:
  - `WAIT_A`: `a<=sw`, go to `WAIT_B`.
  - `WAIT_B`: `b<=sw`, `operands_valid<=1`, go to `READY`.
  - `READY`: `a<=sw`, `operands_valid<=0`, go to `WAIT_B`. `b` holds its old value until it is reloaded.
- `clr_pulse` in any state: `a<=0`, `b<=0`, `operands_valid<=0`, go to `WAIT_A`.
- Simultaneous `clr_pulse` and `load_pulse` in the same clock: clear wins and the load is discarded.
- `sw` changes with no pulse have no effect on the outputs.
- Reset values:
  - `a`=0, `b`=0, `operands_valid`=0, `entry_state`=`WAIT_A`.
  - Synchronisers, `deb`, `deb_q` and counters are all 0.
  - A button held through reset release therefore produces one pulse once it has debounced.
- Reset mid-count: the counter and any pending press are discarded. Reset between the A and B loads returns to `WAIT_A`.

## Timing
- Latency, with `btn_load` stable high from sampling edge 1:
  - Synchroniser output is high after edge 2.
  - `deb` rises at edge 2+`DEBOUNCE_CYCLES`.
  - `a`/`b`/`operands_valid` update at edge 3+`DEBOUNCE_CYCLES`.
- `sw` is captured on that same update edge.
- All outputs are registered directly, with no combinational path from inputs.
- Throughput: at most one accepted press per button per release/press cycle, with a minimum of 2×`DEBOUNCE_CYCLES` clocks between presses.

## Configuration
- Macro: `OPERAND_ENTRY_DEBOUNCE_EN`.
- Defined: debounce filter present as described above.
- Undefined:
  - The filter is removed and `deb` is the synchroniser output.
  - Register update is at edge 3 after the press is first sampled.
  - `DEBOUNCE_CYCLES` and `CNT_W` are ignored.
  - Used for fast simulation and for clean, pre-debounced inputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 with the macro defined, unless stated otherwise.
1. Reset, then `sw`=4'h9 and `btn_load` held for 10 clocks -> at edge 7 `a`=9 and `entry_state`=01; `b`=0; `operands_valid`=0; no second pulse.
2. Continue: release, `sw`=4'hC, press again -> `b`=C, `operands_valid`=1, `entry_state`=10. A third press with `sw`=3 -> `a`=3, `b`=C, `operands_valid`=0, `entry_state`=01.
3. `btn_load` bounces high 3 clocks, low 1, high 2, low -> no update, and the counter is cleared each time.
4. In `READY`, `btn_load` and `btn_clr` pressed on the same clock -> `a`=0, `b`=0, `operands_valid`=0, `entry_state`=00.
5. `rst` asserted asynchronously mid-count in `WAIT_B` with `a`=5 -> outputs are 0 and `WAIT_A` immediately, without waiting for a clock edge.
6. Macro undefined, `btn_load` high at edge 1 -> `a`=`sw` at edge 3.
